ccl_labeler: RTL and testbench

First pass of connected-components labelling. Receives a binary pixel stream with its already-labelled causal neighbours, A/B/C (previous row) and D (left), and assigns a provisional label to every pixel. Label equivalences are recorded in double-buffered merge stacks and drained into an internal merge table, which a second pass queries through a read port. Label width, stack depth and connectivity are all parametrised. Label exhaustion, dropped merges and multi-way merges are detected and reported.

---
 rtl/ccl_labeler.sv | 199 +++++++++++++++++++
 tb/tb_ccl_labeler.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccl_labeler.sv
// ccl_labeler: first pass of connected-components labelling.
// Assigns provisional labels, logs equivalences into ping-pong merge stacks and drains them into a merge table.
module ccl_labeler #(
    parameter int LABEL_W     = 8,
    parameter int STACK_DEPTH = 16,
    parameter int CONN8       = 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               en,
    input  logic               frame_start,
    input  logic [LABEL_W-1:0] A,
    input  logic [LABEL_W-1:0] B,
    input  logic [LABEL_W-1:0] C,
    input  logic [LABEL_W-1:0] D,
    input  logic [LABEL_W-1:0] data,
    input  logic [31:0]        y,
    input  logic [LABEL_W-1:0] rd_addr,
    output logic [LABEL_W-1:0] rd_data,
    output logic [LABEL_W-1:0] q,
    output logic               q_valid,
    output logic [LABEL_W-1:0] num_labels,
    output logic               label_overflow,
    output logic               merge_overflow,
    output logic               merge_incomplete
);

    localparam int CNT_W     = $clog2(STACK_DEPTH + 1);
    localparam int PTR_W     = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int ENT_W     = 2 * LABEL_W;
    localparam int TBL_DEPTH = 1 << LABEL_W;
    localparam logic [LABEL_W-1:0] OVF_LABEL = '1;
    localparam logic [LABEL_W-1:0] FIRST_LABEL = LABEL_W'(1);
    localparam logic [CNT_W-1:0]   FULL_CNT = CNT_W'(STACK_DEPTH);

    logic [LABEL_W-1:0] q_q, q_d;
    logic               q_valid_q, q_valid_d;
    logic [LABEL_W-1:0] num_labels_q, num_labels_d;
    logic               label_overflow_q, label_overflow_d;
    logic               merge_overflow_q, merge_overflow_d;
    logic               merge_incomplete_q, merge_incomplete_d;
    logic [LABEL_W-1:0] rd_data_q, rd_data_d;
    logic [CNT_W-1:0]   cnt_q [2];
    logic [CNT_W-1:0]   cnt_d [2];

    logic [ENT_W-1:0]   stk_mem [2][STACK_DEPTH];
    logic [LABEL_W-1:0] tbl_mem [TBL_DEPTH];

    logic [LABEL_W-1:0] nb [4];
    logic [LABEL_W-1:0] min_lbl, max_lbl;
    logic [2:0]         n_distinct;
    logic               dup;

    logic               pix;
    logic [LABEL_W-1:0] pix_label;
    logic               new_alloc;
    logic               exhausted;
    logic               push_req;
    logic               multi_way;
    logic               push_sel, pop_sel;
    logic               push_full;
    logic               push_en, pop_en;
    logic [PTR_W-1:0]   push_ptr, pop_ptr;
    logic [ENT_W-1:0]   push_entry, pop_entry;
    logic               tbl_we;
    logic [LABEL_W-1:0] tbl_waddr, tbl_wdata;
    logic               unused_y;

    assign unused_y = ^y[31:1];

    // A and C are masked off in 4-connectivity so they never take part in a merge.
    always_comb begin
        nb[0]      = (CONN8 != 0) ? A : '0;
        nb[1]      = B;
        nb[2]      = (CONN8 != 0) ? C : '0;
        nb[3]      = D;
        min_lbl    = '1;
        max_lbl    = '0;
        n_distinct = '0;
        dup        = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (nb[i] != '0) begin
                if (nb[i] < min_lbl) min_lbl = nb[i];
                if (nb[i] > max_lbl) max_lbl = nb[i];
                dup = 1'b0;
                for (int j = 0; j < i; j++) begin
                    if (nb[j] == nb[i]) dup = 1'b1;
                end
                if (!dup) n_distinct = n_distinct + 3'd1;
            end
        end
    end

    always_comb begin
        pix       = reset_n && en && !frame_start;
        exhausted = (num_labels_q == OVF_LABEL);
        pix_label = '0;
        new_alloc = 1'b0;
        push_req  = 1'b0;
        multi_way = 1'b0;
        if (pix && (data != '0)) begin
            if (n_distinct == 3'd0) begin
                // At exhaustion num_labels already equals the overflow label.
                new_alloc = 1'b1;
                pix_label = num_labels_q;
            end else if (n_distinct == 3'd1) begin
                pix_label = min_lbl;
            end else begin
                pix_label = min_lbl;
                push_req  = 1'b1;
                multi_way = (n_distinct >= 3'd3);
            end
        end
    end

    always_comb begin
        push_sel   = y[0];
        pop_sel    = ~y[0];
        push_full  = (cnt_q[push_sel] == FULL_CNT);
        push_en    = push_req && !push_full;
        push_ptr   = PTR_W'(cnt_q[push_sel]);
        push_entry = {max_lbl, min_lbl};
        pop_ptr    = PTR_W'(cnt_q[pop_sel] - CNT_W'(1));
        pop_entry  = stk_mem[pop_sel][pop_ptr];
        // New-label initialisation owns the table port; a blocked pop simply retries.
        pop_en     = reset_n && !frame_start && (cnt_q[pop_sel] != '0) && !new_alloc;
        tbl_we     = new_alloc || pop_en;
        tbl_waddr  = new_alloc ? num_labels_q : pop_entry[ENT_W-1:LABEL_W];
        tbl_wdata  = new_alloc ? num_labels_q : pop_entry[LABEL_W-1:0];
    end

    always_comb begin
        cnt_d[0] = cnt_q[0];
        cnt_d[1] = cnt_q[1];
        if (frame_start) begin
            cnt_d[0] = '0;
            cnt_d[1] = '0;
        end else begin
            if (push_en) cnt_d[push_sel] = cnt_q[push_sel] + CNT_W'(1);
            if (pop_en)  cnt_d[pop_sel]  = cnt_q[pop_sel] - CNT_W'(1);
        end

        q_d       = pix ? pix_label : q_q;
        q_valid_d = pix;
        rd_data_d = tbl_mem[rd_addr];

        if (frame_start) begin
            num_labels_d       = FIRST_LABEL;
            label_overflow_d   = 1'b0;
            merge_overflow_d   = 1'b0;
            merge_incomplete_d = 1'b0;
        end else begin
            num_labels_d       = (new_alloc && !exhausted) ? num_labels_q + LABEL_W'(1)
                                                           : num_labels_q;
            label_overflow_d   = label_overflow_q || (new_alloc && exhausted);
            merge_overflow_d   = merge_overflow_q || (push_req && push_full);
            merge_incomplete_d = merge_incomplete_q || multi_way;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q_q                <= '0;
            q_valid_q          <= 1'b0;
            num_labels_q       <= FIRST_LABEL;
            label_overflow_q   <= 1'b0;
            merge_overflow_q   <= 1'b0;
            merge_incomplete_q <= 1'b0;
            rd_data_q          <= '0;
            cnt_q[0]           <= '0;
            cnt_q[1]           <= '0;
        end else begin
            q_q                <= q_d;
            q_valid_q          <= q_valid_d;
            num_labels_q       <= num_labels_d;
            label_overflow_q   <= label_overflow_d;
            merge_overflow_q   <= merge_overflow_d;
            merge_incomplete_q <= merge_incomplete_d;
            rd_data_q          <= rd_data_d;
            cnt_q[0]           <= cnt_d[0];
            cnt_q[1]           <= cnt_d[1];
        end
    end

    // Storage arrays carry no reset; validity is tracked by the stack counters and label allocation.
    always_ff @(posedge clk) begin
        if (tbl_we) tbl_mem[tbl_waddr] <= tbl_wdata;
        if (push_en && !frame_start) stk_mem[push_sel][push_ptr] <= push_entry;
    end

    assign q                = q_q;
    assign q_valid          = q_valid_q;
    assign num_labels       = num_labels_q;
    assign label_overflow   = label_overflow_q;
    assign merge_overflow   = merge_overflow_q;
    assign merge_incomplete = merge_incomplete_q;
    assign rd_data          = rd_data_q;

endmodule

// File: tb/tb_ccl_labeler.sv
// Bench for ccl_labeler: directed scenarios on three parameterisations plus a randomized run
// against a set-based reference model of labelling, merge stacks and merge table.
module tb_ccl_labeler;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        en, fs;
    logic [7:0]  a, b, c, d, data, rd_addr;
    logic [31:0] y;
    logic [7:0]  rd_data, q, num;
    logic        qv, lovf, movf, minc;
    logic [7:0]  c4_rd, c4_q, c4_num;
    logic        c4_qv, c4_lovf, c4_movf, c4_minc;

    logic        s_en, s_fs;
    logic [3:0]  s_a, s_b, s_c, s_d, s_data, s_rd_addr;
    logic [31:0] s_y;
    logic [3:0]  s_rd, s_q, s_num;
    logic        s_qv, s_lovf, s_movf, s_minc;

    int errors = 0;
    int checks = 0;

    ccl_labeler #(.LABEL_W(8), .STACK_DEPTH(16), .CONN8(1)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .frame_start(fs),
        .A(a), .B(b), .C(c), .D(d), .data(data), .y(y), .rd_addr(rd_addr),
        .rd_data(rd_data), .q(q), .q_valid(qv), .num_labels(num),
        .label_overflow(lovf), .merge_overflow(movf), .merge_incomplete(minc));

    ccl_labeler #(.LABEL_W(8), .STACK_DEPTH(16), .CONN8(0)) dut_c4 (
        .clk(clk), .reset_n(reset_n), .en(en), .frame_start(fs),
        .A(a), .B(b), .C(c), .D(d), .data(data), .y(y), .rd_addr(rd_addr),
        .rd_data(c4_rd), .q(c4_q), .q_valid(c4_qv), .num_labels(c4_num),
        .label_overflow(c4_lovf), .merge_overflow(c4_movf), .merge_incomplete(c4_minc));

    ccl_labeler #(.LABEL_W(4), .STACK_DEPTH(2), .CONN8(1)) dut_s (
        .clk(clk), .reset_n(reset_n), .en(s_en), .frame_start(s_fs),
        .A(s_a), .B(s_b), .C(s_c), .D(s_d), .data(s_data), .y(s_y), .rd_addr(s_rd_addr),
        .rd_data(s_rd), .q(s_q), .q_valid(s_qv), .num_labels(s_num),
        .label_overflow(s_lovf), .merge_overflow(s_movf), .merge_incomplete(s_minc));

    // Reference model state (main instance, LABEL_W=8, STACK_DEPTH=16, 8-connectivity)
    int m_num, m_q;
    bit m_qv, m_lovf, m_movf, m_minc;
    int m_stk0[$];
    int m_stk1[$];
    int m_tbl[256];
    bit m_known[256];
    int e_rd;
    bit e_rd_known;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_num = 1; m_q = 0; m_qv = 0;
        m_lovf = 0; m_movf = 0; m_minc = 0;
        m_stk0.delete(); m_stk1.delete();
        for (int i = 0; i < 256; i++) begin
            m_known[i] = 0;
            m_tbl[i] = 0;
        end
    endtask

    task automatic model_step();
        int nb[4];
        int u[$];
        bit seen;
        int lbl;
        bit new_w;
        int e;
        int sp;
        e_rd_known = m_known[rd_addr];
        e_rd = m_tbl[rd_addr];
        new_w = 0;
        sp = int'(y[0]);
        if (fs) begin
            m_num = 1; m_lovf = 0; m_movf = 0; m_minc = 0; m_qv = 0;
            m_stk0.delete(); m_stk1.delete();
        end else if (en) begin
            nb = '{int'(a), int'(b), int'(c), int'(d)};
            for (int i = 0; i < 4; i++) begin
                if (nb[i] != 0) begin
                    seen = 0;
                    for (int k = 0; k < u.size(); k++) if (u[k] == nb[i]) seen = 1;
                    if (!seen) u.push_back(nb[i]);
                end
            end
            u.sort();
            if (data == 0) begin
                lbl = 0;
            end else if (u.size() == 0) begin
                lbl = m_num;
                new_w = 1;
                if (m_num == 255) m_lovf = 1;
                else m_num = m_num + 1;
                m_tbl[lbl] = lbl;
                m_known[lbl] = 1;
            end else begin
                lbl = u[0];
                if (u.size() > 1) begin
                    e = u[u.size()-1] * 256 + u[0];
                    if (sp == 0) begin
                        if (m_stk0.size() >= 16) m_movf = 1; else m_stk0.push_back(e);
                    end else begin
                        if (m_stk1.size() >= 16) m_movf = 1; else m_stk1.push_back(e);
                    end
                    if (u.size() >= 3) m_minc = 1;
                end
            end
            m_q = lbl;
            m_qv = 1;
        end else begin
            m_qv = 0;
        end
        if (!fs && !new_w) begin
            if (sp == 1 && m_stk0.size() > 0) begin
                e = m_stk0.pop_back();
                m_tbl[e / 256] = e % 256;
                m_known[e / 256] = 1;
            end else if (sp == 0 && m_stk1.size() > 0) begin
                e = m_stk1.pop_back();
                m_tbl[e / 256] = e % 256;
                m_known[e / 256] = 1;
            end
        end
    endtask

    function automatic logic [7:0] rnd_nb();
        if ($urandom_range(0, 9) < 6) return 8'd0;
        if ($urandom_range(0, 4) == 0) return 8'($urandom_range(1, 255));
        return 8'($urandom_range(1, (m_num > 1) ? m_num : 1));
    endfunction

    task automatic test_reset();
        reset_n = 0;
        tick(); tick();
        checks++; if (q !== 8'd0 || qv !== 1'b0) begin errors++; $display("FAIL reset_q: q=%0d qv=%0d want 0 0", q, qv); end
        checks++; if (num !== 8'd1) begin errors++; $display("FAIL reset_num: got %0d want 1", num); end
        checks++; if (rd_data !== 8'd0) begin errors++; $display("FAIL reset_rd: got %0d want 0", rd_data); end
        checks++; if ({lovf, movf, minc} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b want 000", {lovf, movf, minc}); end
        checks++; if (s_num !== 4'd1 || s_qv !== 1'b0 || s_rd !== 4'd0) begin errors++; $display("FAIL reset_small: num=%0d qv=%0d rd=%0d want 1 0 0", s_num, s_qv, s_rd); end
        reset_n = 1;
    endtask

    task automatic test_new_label();
        en = 1; data = 1; a = 0; b = 0; c = 0; d = 0; y = 0;
        tick();
        checks++; if (q !== 8'd1 || qv !== 1'b1) begin errors++; $display("FAIL new_q: q=%0d qv=%0d want 1 1", q, qv); end
        checks++; if (num !== 8'd2) begin errors++; $display("FAIL new_num: got %0d want 2", num); end
        en = 0; rd_addr = 1;
        tick();
        checks++; if (rd_data !== 8'd1) begin errors++; $display("FAIL new_table: got %0d want 1", rd_data); end
        checks++; if (qv !== 1'b0 || q !== 8'd1) begin errors++; $display("FAIL idle_hold: q=%0d qv=%0d want 1 0", q, qv); end
    endtask

    task automatic test_connectivity();
        en = 1; data = 1; a = 3; c = 3; b = 0; d = 0;
        tick();
        checks++; if (q !== 8'd3 || num !== 8'd2) begin errors++; $display("FAIL copy8: q=%0d num=%0d want 3 2", q, num); end
        checks++; if (c4_q !== 8'd2 || c4_num !== 8'd3) begin errors++; $display("FAIL copy4_new: q=%0d num=%0d want 2 3", c4_q, c4_num); end
        en = 0; a = 0; c = 0;
    endtask

    task automatic test_merge();
        y = 0; en = 1; data = 1; a = 2; c = 5; b = 0; d = 0;
        tick();
        checks++; if (q !== 8'd2 || num !== 8'd2 || minc !== 1'b0) begin errors++; $display("FAIL merge_q: q=%0d num=%0d minc=%0d want 2 2 0", q, num, minc); end
        en = 0; a = 0; c = 0; y = 1;
        tick();
        rd_addr = 5;
        tick();
        checks++; if (rd_data !== 8'd2) begin errors++; $display("FAIL merge_drain: table[5]=%0d want 2", rd_data); end
    endtask

    task automatic test_collision();
        y = 1; en = 1; data = 1; a = 1; c = 2; b = 0; d = 0;
        tick();
        checks++; if (q !== 8'd1) begin errors++; $display("FAIL coll_merge: q=%0d want 1", q); end
        y = 0; a = 0; c = 0;
        tick();
        checks++; if (q !== 8'd2 || num !== 8'd3) begin errors++; $display("FAIL coll_new: q=%0d num=%0d want 2 3", q, num); end
        en = 0; rd_addr = 2;
        tick();
        checks++; if (rd_data !== 8'd2) begin errors++; $display("FAIL coll_init_first: table[2]=%0d want 2", rd_data); end
        tick();
        checks++; if (rd_data !== 8'd1) begin errors++; $display("FAIL coll_retry: table[2]=%0d want 1", rd_data); end
    endtask

    task automatic test_small_overflow();
        s_en = 1; s_data = 1; s_a = 0; s_b = 0; s_c = 0; s_d = 0; s_y = 0;
        for (int i = 1; i <= 14; i++) begin
            tick();
            checks++; if (s_q !== 4'(i) || s_num !== 4'(i + 1)) begin errors++; $display("FAIL small_alloc%0d: q=%0d num=%0d want %0d %0d", i, s_q, s_num, i, i + 1); end
        end
        checks++; if (s_lovf !== 1'b0) begin errors++; $display("FAIL small_lovf_early: got %0d want 0", s_lovf); end
        tick();
        checks++; if (s_q !== 4'd15 || s_lovf !== 1'b1 || s_num !== 4'd15) begin errors++; $display("FAIL label_ovf: q=%0d lovf=%0d num=%0d want 15 1 15", s_q, s_lovf, s_num); end
        s_fs = 1;
        tick();
        checks++; if (s_num !== 4'd1 || s_lovf !== 1'b0 || s_qv !== 1'b0) begin errors++; $display("FAIL fs_clear: num=%0d lovf=%0d qv=%0d want 1 0 0", s_num, s_lovf, s_qv); end
        s_fs = 0;
    endtask

    task automatic test_small_merges();
        s_en = 1; s_data = 1; s_y = 0; s_a = 1; s_b = 0; s_d = 0;
        for (int i = 2; i <= 4; i++) begin
            s_c = 4'(i);
            tick();
            checks++; if (s_movf !== ((i == 4) ? 1'b1 : 1'b0) || s_q !== 4'd1) begin errors++; $display("FAIL stack_fill%0d: movf=%0d q=%0d want %0d 1", i, s_movf, s_q, (i == 4)); end
        end
        s_y = 1; s_a = 2; s_c = 4; s_d = 6;
        tick();
        checks++; if (s_q !== 4'd2 || s_minc !== 1'b1) begin errors++; $display("FAIL multi_way: q=%0d minc=%0d want 2 1", s_q, s_minc); end
        s_en = 0; s_a = 0; s_c = 0; s_d = 0;
        tick(); tick();
        s_y = 0;
        tick(); tick();
        s_rd_addr = 6; tick();
        checks++; if (s_rd !== 4'd2) begin errors++; $display("FAIL small_t6: got %0d want 2", s_rd); end
        s_rd_addr = 3; tick();
        checks++; if (s_rd !== 4'd1) begin errors++; $display("FAIL small_t3: got %0d want 1", s_rd); end
        s_rd_addr = 2; tick();
        checks++; if (s_rd !== 4'd1) begin errors++; $display("FAIL small_t2: got %0d want 1", s_rd); end
        s_rd_addr = 4; tick();
        checks++; if (s_rd !== 4'd4) begin errors++; $display("FAIL dropped_merge: table[4]=%0d want 4", s_rd); end
    endtask

    task automatic test_random();
        int row_left;
        en = 0; fs = 0; a = 0; b = 0; c = 0; d = 0; data = 0; y = 0; rd_addr = 0;
        reset_n = 0;
        tick();
        reset_n = 1;
        model_reset();
        row_left = $urandom_range(8, 60);
        for (int n = 0; n < 6000; n++) begin
            fs = (n == 0) || ($urandom_range(0, 1499) == 0);
            en = ($urandom_range(0, 3) != 0);
            data = ($urandom_range(0, 9) < 7) ? 8'($urandom_range(1, 255)) : 8'd0;
            a = rnd_nb(); b = rnd_nb(); c = rnd_nb(); d = rnd_nb();
            rd_addr = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, (m_num > 1) ? m_num : 1));
            row_left--;
            if (row_left == 0) begin
                y = y + 1;
                row_left = $urandom_range(8, 60);
            end
            model_step();
            tick();
            checks++;
            if ({q, qv, num, lovf, movf, minc} !== {8'(m_q), m_qv, 8'(m_num), m_lovf, m_movf, m_minc}) begin
                errors++;
                $display("FAIL rand%0d: q=%0d qv=%0d num=%0d flags=%b%b%b want q=%0d qv=%0d num=%0d flags=%b%b%b",
                         n, q, qv, num, lovf, movf, minc, m_q, m_qv, m_num, m_lovf, m_movf, m_minc);
            end
            if (e_rd_known) begin
                checks++;
                if (rd_data !== 8'(e_rd)) begin
                    errors++;
                    $display("FAIL rand_rd%0d: table=%0d want %0d", n, rd_data, e_rd);
                end
            end
        end
    endtask

    initial begin
        reset_n = 0; en = 0; fs = 0; a = 0; b = 0; c = 0; d = 0; data = 0; y = 0; rd_addr = 0;
        s_en = 0; s_fs = 0; s_a = 0; s_b = 0; s_c = 0; s_d = 0; s_data = 0; s_y = 0; s_rd_addr = 0;
        test_reset();
        test_new_label();
        test_connectivity();
        test_merge();
        test_collision();
        test_small_overflow();
        test_small_merges();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
